// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared types, defaults and width helper for the sequence detectors
package seq_detect_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_DATA_W  = 8;

    // Bits needed to hold a pattern length in the range 0..max_len
    function automatic int LEN_W(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/pattern_match_core.sv
// rtl/pattern_match_core.sv - bit history, fill tracking and registered pattern compare
module pattern_match_core
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       shift_en,
    input  logic                       shift_bit,
    input  logic                       clear,
    input  logic [MAX_LEN-1:0]         pat,
    input  logic [LEN_W(MAX_LEN)-1:0]  len,
    input  logic                       ovl,
    output logic                       match
);

    localparam int            LW       = LEN_W(MAX_LEN);
    localparam logic [LW-1:0] FILL_ONE = LW'(1);
    localparam logic [LW-1:0] FILL_MAX = LW'(MAX_LEN);

    // Only MAX_LEN-1 old bits are stored; the incoming bit completes the window
    logic [MAX_LEN-2:0] hist;
    logic [MAX_LEN-1:0] next_hist;
    logic [MAX_LEN-1:0] len_mask;
    logic [LW-1:0]      fill;
    logic [LW-1:0]      next_fill;
    logic               hit;

    // Window after the incoming bit and its compare against the low len pattern bits
    always_comb begin
        next_hist = {hist, shift_bit};
        next_fill = (fill == FILL_MAX) ? fill : fill + FILL_ONE;
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LW'(i) < len);
        end
        hit = (((next_hist ^ pat) & len_mask) == '0) && (next_fill >= len);
    end

    // History/fill update and match register; a clear discards a coincident bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist  <= '0;
            fill  <= '0;
            match <= 1'b0;
        end else begin
            match <= 1'b0;
            if (clear) begin
                hist <= '0;
                fill <= '0;
            end else if (shift_en) begin
                hist  <= next_hist[MAX_LEN-2:0];
                match <= hit;
                fill  <= (hit && !ovl) ? '0 : next_fill;
            end
        end
    end

endmodule

// File: rtl/seq_stream_ctrl.sv
// rtl/seq_stream_ctrl.sv - byte stream serializer and programmable sequence detector (option: SEQ_MATCH_CNT_EN)
module seq_stream_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int DATA_W  = DEF_DATA_W
`ifdef SEQ_MATCH_CNT_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      cfg_we,
    input  logic [MAX_LEN-1:0]        cfg_pat,
    input  logic [LEN_W(MAX_LEN)-1:0] cfg_len,
    input  logic                      cfg_ovl,
    input  logic                      flush,
    output logic                      busy,
    output logic                      match
`ifdef SEQ_MATCH_CNT_EN
    ,
    input  logic                      cnt_clr,
    output logic [CNT_W-1:0]          match_cnt
`endif
);

    localparam int               LW       = LEN_W(MAX_LEN);
    localparam int               IDX_W    = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [LW-1:0]    LEN_MIN  = LW'(1);
    localparam logic [LW-1:0]    LEN_MAX  = LW'(MAX_LEN);

    state_t             state;
    logic [DATA_W-1:0]  word;
    logic [IDX_W-1:0]   bit_idx;
    logic [MAX_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    logic               ovl_q;
    logic [LW-1:0]      len_clamped;
    logic               hs;
    logic               cfg_wr;

    // Ready while idle or while the last bit of the current word is going out
    assign in_ready = (state == IDLE) || (bit_idx == '0);
    assign busy     = (state == SHIFT);
    assign hs       = in_valid && in_ready;
    assign cfg_wr   = cfg_we && (state == IDLE) && !hs;

    // A zero length acts as one bit; lengths beyond the history are cut to MAX_LEN
    always_comb begin
        len_clamped = cfg_len;
        if (cfg_len == '0) begin
            len_clamped = LEN_MIN;
        end else if (cfg_len > LEN_MAX) begin
            len_clamped = LEN_MAX;
        end
    end

    // Handshake/serializer FSM plus the config latch, which only loads while idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            word    <= '0;
            bit_idx <= '0;
            pat_q   <= '0;
            len_q   <= LEN_MIN;
            ovl_q   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        word    <= in_data;
                        bit_idx <= IDX_LAST;
                        state   <= SHIFT;
                    end else if (cfg_we) begin
                        pat_q <= cfg_pat;
                        len_q <= len_clamped;
                        ovl_q <= cfg_ovl;
                    end
                end
                SHIFT: begin
                    if (bit_idx == '0) begin
                        if (hs) begin
                            word    <= in_data;
                            bit_idx <= IDX_LAST;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        bit_idx <= bit_idx - IDX_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pattern_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (busy),
        .shift_bit (word[bit_idx]),
        .clear     (flush || cfg_wr),
        .pat       (pat_q),
        .len       (len_q),
        .ovl       (ovl_q),
        .match     (match)
    );

`ifdef SEQ_MATCH_CNT_EN
    // Saturating count of match pulses; clear beats a coincident pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != '1)) begin
            match_cnt <= match_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// tb/tb_seq_stream_ctrl.sv - directed and randomized checks of seq_stream_ctrl against a bit-queue model
module tb_seq_stream_ctrl;

    localparam int MAX_LEN = 8;
    localparam int DATA_W  = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);
`ifdef SEQ_MATCH_CNT_EN
    localparam int CNT_W   = 16;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [DATA_W-1:0]  in_data = '0;
    logic               cfg_we = 1'b0;
    logic [MAX_LEN-1:0] cfg_pat = '0;
    logic [LW-1:0]      cfg_len = '0;
    logic               cfg_ovl = 1'b0;
    logic               flush = 1'b0;
    logic               busy;
    logic               match;
`ifdef SEQ_MATCH_CNT_EN
    logic               cnt_clr = 1'b0;
    logic [CNT_W-1:0]   match_cnt;
`endif

    seq_stream_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .cfg_we    (cfg_we),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
        .flush     (flush),
        .busy      (busy),
        .match     (match)
`ifdef SEQ_MATCH_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model: bits waiting to be shifted, bits already shifted, and config
    int                 pend[$];
    int                 hist[$];
    int                 fill;
    logic [MAX_LEN-1:0] m_pat;
    int                 m_len;
    bit                 m_ovl;
    bit                 exp_match;
    int                 exp_cnt;

    int seen_match;
    int seen_busy;
    int seen_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        pend.delete();
        hist.delete();
        fill      = 0;
        m_pat     = '0;
        m_len     = 1;
        m_ovl     = 1'b1;
        exp_match = 1'b0;
        exp_cnt   = 0;
    endtask

    task automatic model_clear();
        hist.delete();
        fill = 0;
    endtask

    function automatic bit model_hit();
        if (fill < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (hist[hist.size() - 1 - k] != int'(m_pat[k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic clear_seen();
        seen_match = 0;
        seen_busy  = 0;
        seen_acc   = 0;
    endtask

    // One clock: check outputs, drive inputs, advance model, move to next falling edge
    task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit cw,
                        input logic [MAX_LEN-1:0] cp, input logic [LW-1:0] cl,
                        input bit co, input bit fl, input bit cc);
        bit rdy;
        bit hs;
        bit cfgw;
        bit nm;
        int b;
        rdy = (pend.size() <= 1);
        check("in_ready", in_ready, rdy);
        check("busy", busy, pend.size() >= 1);
        check("match", match, exp_match);
`ifdef SEQ_MATCH_CNT_EN
        check("match_cnt", match_cnt, exp_cnt);
        if (cc) exp_cnt = 0;
        else if (exp_match && exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
        cnt_clr = cc;
`endif
        seen_match += int'(match);
        seen_busy  += int'(busy);
        seen_acc   += int'(v && in_ready);

        in_valid = v;
        in_data  = d;
        cfg_we   = cw;
        cfg_pat  = cp;
        cfg_len  = cl;
        cfg_ovl  = co;
        flush    = fl;

        hs   = v && rdy;
        cfgw = cw && (pend.size() == 0) && !hs;
        nm   = 1'b0;
        if (pend.size() > 0) begin
            b = pend.pop_front();
            if (fl) begin
                model_clear();
            end else begin
                hist.push_back(b);
                if (hist.size() > MAX_LEN) void'(hist.pop_front());
                if (fill < MAX_LEN) fill++;
                nm = model_hit();
                if (nm && !m_ovl) fill = 0;
            end
        end else if (fl) begin
            model_clear();
        end
        if (cfgw) begin
            m_pat = cp;
            m_len = (cl == 0) ? 1 : ((int'(cl) > MAX_LEN) ? MAX_LEN : int'(cl));
            m_ovl = co;
            model_clear();
        end
        if (hs) begin
            for (int i = DATA_W - 1; i >= 0; i--) pend.push_back(int'(d[i]));
        end
        exp_match = nm;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send(input logic [DATA_W-1:0] d);
        step(1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic configure(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input bit o);
        step(1'b0, '0, 1'b1, p, l, o, 1'b0, 1'b1);
    endtask

    initial begin
        bit                 rv;
        bit                 rw;
        bit                 rf;
        bit                 rc;
        logic [LW-1:0]      rl;

        model_reset();
        clear_seen();
        repeat (2) @(negedge clk);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_match", match, 1'b0);
        rst = 1'b1;

        // Overlapping 101 on 1010_1000: pulses after bits 3 and 5
        configure(8'b0000_0101, 4'd3, 1'b1);
        clear_seen();
        send(8'b1010_1000);
        idle(10);
        check("pulses_ovl1", seen_match, 2);
`ifdef SEQ_MATCH_CNT_EN
        check("cnt_ovl1", match_cnt, 2);
`endif

        // Non-overlapping: only the first 101
        configure(8'b0000_0101, 4'd3, 1'b0);
        clear_seen();
        send(8'b1010_1000);
        idle(10);
        check("pulses_ovl0", seen_match, 1);

        // Three words with in_valid held high: accepted at 0, 8, 16; 24 busy cycles
        clear_seen();
        for (int i = 0; i < 17; i++) send(DATA_W'($urandom));
        idle(9);
        check("accepts_b2b", seen_acc, 3);
        check("busy_b2b", seen_busy, 24);

        // Flush on the completing bit of 101, then 0,1 must not match
        configure(8'b0000_0101, 4'd3, 1'b1);
        clear_seen();
        send(8'b1010_1000);
        idle(2);
        step(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(8);
        check("pulses_flush", seen_match, 0);

        // Config write during SHIFT is ignored
        clear_seen();
        send(8'h05);
        step(1'b0, '0, 1'b1, 8'hFF, 4'd8, 1'b0, 1'b0, 1'b0);
        idle(9);
        check("pulses_cfg_in_shift", seen_match, 1);

        // Length 0 behaves as length 1
        configure(8'h01, 4'd0, 1'b1);
        clear_seen();
        send(8'h80);
        idle(10);
        check("pulses_len0", seen_match, 1);

        // Asynchronous reset three bits into a word
        send(8'hC3);
        idle(3);
        #2 rst = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_match", match, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_seen();
        send(8'h80);
        idle(10);
        check("pulses_after_reset", seen_match, 7);

        // Randomized traffic, config, flush and counter clears
        for (int n = 0; n < 1500; n++) begin
            rv = ($urandom_range(0, 1) == 0);
            rw = ($urandom_range(0, 7) == 0);
            rf = ($urandom_range(0, 31) == 0);
            rc = ($urandom_range(0, 63) == 0);
            rl = ($urandom_range(0, 3) == 0) ? LW'($urandom_range(0, 15)) : LW'($urandom_range(1, 3));
            step(rv, DATA_W'($urandom), rw, MAX_LEN'($urandom), rl, 1'($urandom), rf, rc);
        end
        idle(12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
